// File: rtl/lj_accumulator.sv
// Per-reference accumulator for DT-scaled 3-lane fp32 Lennard-Jones pair results.
// Sums beats of one reference particle and emits the total through a one-entry output register.

module fp32_add (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_y
);
  logic [31:0] w_big, w_sml;
  logic [7:0]  w_eb, w_es, w_d;
  logic [26:0] w_mb, w_ms, w_msh, w_n;
  logic [27:0] w_sum;
  logic [24:0] w_m;
  logic [9:0]  w_e;
  logic        w_rnd, w_nan;

  always_comb begin
    // Order operands by magnitude so the mantissa difference never goes negative
    w_big = i_a;
    w_sml = i_b;
    if (i_b[30:0] > i_a[30:0]) begin
      w_big = i_b;
      w_sml = i_a;
    end
    w_nan = (&i_a[30:23] && |i_a[22:0]) || (&i_b[30:23] && |i_b[22:0]);
    w_eb  = (w_big[30:23] == 8'd0) ? 8'd1 : w_big[30:23];
    w_es  = (w_sml[30:23] == 8'd0) ? 8'd1 : w_sml[30:23];
    w_mb  = {|w_big[30:23], w_big[22:0], 3'b000};
    w_ms  = {|w_sml[30:23], w_sml[22:0], 3'b000};
    w_d   = w_eb - w_es;
    if (w_d > 8'd26) w_msh = {26'd0, |w_ms};
    else             w_msh = (w_ms >> w_d) | {26'd0, |(w_ms & ((27'd1 << w_d) - 27'd1))};
    if (w_big[31] ^ w_sml[31]) w_sum = {1'b0, w_mb} - {1'b0, w_msh};
    else                       w_sum = {1'b0, w_mb} + {1'b0, w_msh};
    w_e = {2'b00, w_eb};
    if (w_sum[27]) begin
      w_n = {w_sum[27:2], |w_sum[1:0]};
      w_e = w_e + 10'd1;
    end else begin
      w_n = w_sum[26:0];
      for (int i = 0; i < 26; i++)
        if (!w_n[26] && w_e > 10'd1) begin
          w_n = w_n << 1;
          w_e = w_e - 10'd1;
        end
    end
    // Round to nearest, ties to even; an unset hidden bit afterwards means subnormal
    w_rnd = w_n[2] & (w_n[1] | w_n[0] | w_n[3]);
    w_m   = {1'b0, w_n[26:3]} + {24'd0, w_rnd};
    if (w_m[24]) begin
      w_m = w_m >> 1;
      w_e = w_e + 10'd1;
    end
    if (w_nan)                        o_y = 32'h7FC0_0000;
    else if (&w_big[30:23])           o_y = (&w_sml[30:23] && (w_big[31] ^ w_sml[31])) ? 32'h7FC0_0000 : w_big;
    else if (w_sum == 28'd0)          o_y = {w_big[31] & w_sml[31], 31'd0};
    else if (w_e >= 10'd255)          o_y = {w_big[31], 8'hFF, 23'd0};
    else                              o_y = {w_big[31], w_m[23] ? w_e[7:0] : 8'd0, w_m[22:0]};
  end
endmodule

module lj_accumulator #(
  parameter int ID_W  = 16,
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0][31:0] in_lj,
  input  logic [ID_W-1:0]  in_ref_id,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0][31:0] out_sum,
  output logic [ID_W-1:0]  out_ref_id,
  output logic [CNT_W-1:0] out_count,
  output logic             err_id
);
  localparam int NUM_LANES = 3;
  localparam int VEC_W     = 32;

  typedef enum logic {EMPTY, ACCUM} state_t;

  state_t                          r_state;
  logic [NUM_LANES-1:0][VEC_W-1:0] r_acc, w_acc_next, r_out_sum;
  logic [ID_W-1:0]                 r_acc_id, r_out_id, w_id_sel;
  logic [CNT_W-1:0]                r_acc_cnt, r_out_cnt, w_cnt_inc;
  logic                            r_out_valid, r_err_id, w_accept;

  genvar gl;
  generate
    for (gl = 0; gl < NUM_LANES; gl++) begin : g_lane
      fp32_add u_add (.i_a(r_acc[gl]), .i_b(in_lj[gl]), .o_y(w_acc_next[gl]));
    end
  endgenerate

  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_cnt_inc = (&r_acc_cnt) ? r_acc_cnt : r_acc_cnt + CNT_W'(1);
  assign w_id_sel  = (r_state == ACCUM) ? r_acc_id : in_ref_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_acc       <= '0;
      r_acc_id    <= '0;
      r_acc_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_id    <= '0;
      r_out_cnt   <= '0;
      r_err_id    <= 1'b0;
    end else begin
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      if (w_accept) begin
        // A mismatched beat is still summed under the group's original ID
        if (r_state == ACCUM && in_ref_id != r_acc_id) r_err_id <= 1'b1;
        if (in_last) begin
          r_out_valid <= 1'b1;
          r_out_sum   <= w_acc_next;
          r_out_id    <= w_id_sel;
          r_out_cnt   <= w_cnt_inc;
          r_acc       <= '0;
          r_acc_cnt   <= '0;
          r_state     <= EMPTY;
        end else begin
          r_acc     <= w_acc_next;
          r_acc_cnt <= w_cnt_inc;
          r_state   <= ACCUM;
          if (r_state == EMPTY) r_acc_id <= in_ref_id;
        end
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_sum    = r_out_sum;
  assign out_ref_id = r_out_id;
  assign out_count  = r_out_cnt;
  assign err_id     = r_err_id;
endmodule

// File: tb/tb_lj_accumulator.sv
// Scoreboard bench for lj_accumulator: directed groups push expected totals,
// a monitor compares every presented total against the queue head.

module tb_lj_accumulator;
  localparam int ID_W  = 16;
  localparam int CNT_W = 2;

  localparam logic [31:0] F_HALF = 32'h3F00_0000;
  localparam logic [31:0] F_ONE  = 32'h3F80_0000;
  localparam logic [31:0] F_1P5  = 32'h3FC0_0000;
  localparam logic [31:0] F_TWO  = 32'h4000_0000;
  localparam logic [31:0] F_THR  = 32'h4040_0000;
  localparam logic [31:0] F_3P5  = 32'h4060_0000;
  localparam logic [31:0] F_FIVE = 32'h40A0_0000;
  localparam logic [31:0] F_MONE = 32'hBF80_0000;

  typedef struct {
    logic [95:0]      sum;
    logic [ID_W-1:0]  id;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [95:0]      in_lj = '0;
  logic [ID_W-1:0]  in_ref_id = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [95:0]      out_sum;
  logic [ID_W-1:0]  out_ref_id;
  logic [CNT_W-1:0] out_count;
  logic             err_id;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_fail = 0;

  lj_accumulator #(.ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_lj(in_lj),
    .in_ref_id(in_ref_id), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_ref_id(out_ref_id), .out_count(out_count), .err_id(err_id)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [95:0] act, input logic [95:0] want);
    if (act === want) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endfunction

  function automatic logic [95:0] vec(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return {z, y, x};
  endfunction

  function automatic void expect_total(input logic [95:0] s, input logic [ID_W-1:0] id, input logic [CNT_W-1:0] c);
    exp_t e;
    e.sum = s; e.id = id; e.cnt = c;
    exp_q.push_back(e);
  endfunction

  // Drive one beat from a negedge; returns at the negedge after acceptance
  task automatic send(input logic [95:0] lj, input logic [ID_W-1:0] id, input logic last);
    int g = 0;
    in_valid = 1'b1; in_lj = lj; in_ref_id = id; in_last = last;
    #1;
    while (!in_ready && g < 100) begin
      @(negedge clk); #1;
      g++;
    end
    if (g >= 100) begin
      n_fail++;
      $display("FAIL send_timeout: in_ready stuck low for id %0d", id);
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Monitor: compare the head of the queue while a total is presented
  always begin
    @(negedge clk); #2;
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got id %0d sum %h with nothing expected", out_ref_id, out_sum);
      end else begin
        chk("out_sum",    out_sum,           exp_q[0].sum);
        chk("out_ref_id", 96'(out_ref_id),   96'(exp_q[0].id));
        chk("out_count",  96'(out_count),    96'(exp_q[0].cnt));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready",  96'(in_ready),   96'(1));
    chk("rst_out_valid", 96'(out_valid),  96'(0));
    chk("rst_out_sum",   out_sum,         96'h0);
    chk("rst_out_id",    96'(out_ref_id), 96'(0));
    chk("rst_out_count", 96'(out_count),  96'(0));
    chk("rst_err_id",    96'(err_id),     96'(0));
    @(negedge clk);

    // Three-beat group: 1.0 + 2.0 + 0.5 = 3.5
    expect_total(vec(F_3P5, 32'h0, 32'h0), 16'd5, 2'd3);
    send(vec(F_ONE, 32'h0, 32'h0), 16'd5, 1'b0);
    send(vec(F_TWO, 32'h0, 32'h0), 16'd5, 1'b0);
    #1 chk("no_early_valid", 96'(out_valid), 96'(0));
    send(vec(F_HALF, 32'h0, 32'h0), 16'd5, 1'b1);
    #1 chk("latency_valid", 96'(out_valid), 96'(1));

    // Single-beat group right behind it
    expect_total(vec(F_MONE, F_1P5, 32'h0), 16'd9, 2'd1);
    send(vec(F_MONE, F_1P5, 32'h0), 16'd9, 1'b1);
    #1 chk("single_in_ready", 96'(in_ready), 96'(1));
    @(negedge clk);

    // Backpressure: first total held, second group stalls until release
    out_ready = 1'b0;
    expect_total(vec(F_TWO, 32'h0, 32'h0), 16'd1, 2'd2);
    send(vec(F_ONE, 32'h0, 32'h0), 16'd1, 1'b0);
    send(vec(F_ONE, 32'h0, 32'h0), 16'd1, 1'b1);
    #1 chk("bp_valid", 96'(out_valid), 96'(1));
    chk("bp_in_ready_low", 96'(in_ready), 96'(0));
    expect_total(vec(F_THR, 32'h0, 32'h0), 16'd2, 2'd1);
    fork
      send(vec(F_THR, 32'h0, 32'h0), 16'd2, 1'b1);
      begin
        repeat (4) begin
          @(negedge clk); #1;
          chk("bp_stall", 96'(in_ready), 96'(0));
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    @(negedge clk);

    // ID fault: sum continues under the first ID
    expect_total(vec(F_TWO, 32'h0, 32'h0), 16'd3, 2'd2);
    send(vec(F_ONE, 32'h0, 32'h0), 16'd3, 1'b0);
    #1 chk("err_before", 96'(err_id), 96'(0));
    send(vec(F_ONE, 32'h0, 32'h0), 16'd4, 1'b1);
    #1 chk("err_set", 96'(err_id), 96'(1));
    expect_total(vec(F_ONE, 32'h0, 32'h0), 16'd10, 2'd1);
    send(vec(F_ONE, 32'h0, 32'h0), 16'd10, 1'b1);
    @(negedge clk);
    #1 chk("err_sticky", 96'(err_id), 96'(1));

    // Reset mid-group discards the partial sum
    send(vec(F_ONE, 32'h0, 32'h0), 16'd7, 1'b0);
    send(vec(F_ONE, 32'h0, 32'h0), 16'd7, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("mid_rst_valid", 96'(out_valid), 96'(0));
    chk("mid_rst_err", 96'(err_id), 96'(0));
    expect_total(vec(F_TWO, 32'h0, 32'h0), 16'd8, 2'd1);
    send(vec(F_TWO, 32'h0, 32'h0), 16'd8, 1'b1);

    // Saturating count: five beats, counter tops out at 3
    expect_total(vec(F_FIVE, 32'h0, 32'h0), 16'd11, 2'd3);
    for (int i = 0; i < 5; i++)
      send(vec(F_ONE, 32'h0, 32'h0), 16'd11, (i == 4));

    repeat (4) @(negedge clk);
    chk("queue_drained", 96'(exp_q.size()), 96'(0));
    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end
endmodule

// File: doc/lj_accumulator.md
# lj_accumulator

Per-reference force/velocity-delta accumulator downstream of the Lennard-Jones pair stage. It consumes the stream of DT-scaled 3-lane fp32 pair results, one neighbor pair per beat. It sums all beats belonging to one reference particle and emits the per-particle total with its ID and pair count to the velocity-update stage. Throughput is one pair per cycle; a one-entry output register decouples downstream backpressure.

## Interface
- `ID_W`, 16: width of reference particle ID.
- `CNT_W`, 12: width of pair counter; saturates.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  pair beat valid.
- `in_ready`  out  1  beat accepted when `in_valid && in_ready`.
- `in_lj`  in  96  pair result; lanes x=[31:0], y=[63:32], z=[95:64], fp32.
- `in_ref_id`  in  ID_W  reference particle of this beat.
- `in_last`  in  1  final pair for this reference.
- `out_valid`  out  1  total available.
- `out_ready`  in  1  downstream takes total when `out_valid && out_ready`.
- `out_sum`  out  96  per-lane fp32 sum, same lane layout.
- `out_ref_id`  out  ID_W  reference ID of the total.
- `out_count`  out  CNT_W  pairs summed, saturated at 2^CNT_W-1.
- `err_id`  out  1  sticky: reference ID changed mid-group.

## Operation
- Datapath: three combinational `fp32_add` instances, `acc_next[lane] = acc[lane] + in_lj[lane]`. The accumulator registers `acc`, `acc_id` and `acc_cnt` update only on an accepted beat.
- State machine, two states:
  - EMPTY: acc = 32'h0 per lane, acc_cnt = 0.
  - ACCUM: at least one beat absorbed, group still open.
- EMPTY, accepted beat, `in_last`=0: acc <= acc_next, acc_id <= in_ref_id, acc_cnt <= 1. Go to ACCUM.
- EMPTY, accepted beat, `in_last`=1: load the output register with acc_next, in_ref_id and count 1. Stay in EMPTY.
- ACCUM, accepted beat, `in_last`=0: acc <= acc_next, acc_cnt <= sat(acc_cnt+1).
- ACCUM, accepted beat, `in_last`=1: load the output register with acc_next, acc_id and sat(acc_cnt+1). Clear acc to +0 and acc_cnt to 0. Go to EMPTY.
- ID check: in ACCUM, an accepted beat with `in_ref_id != acc_id` sets `err_id`. The beat is still summed under acc_id. `err_id` clears only on `rst`.
- Output register:
  - `out_valid` sets on load and clears on `out_ready` handshake without a same-cycle load.
  - A same-cycle handshake plus load keeps `out_valid`=1 with the new contents.
- Backpressure: `in_ready = !out_valid || out_ready`, combinational. All beats stall while a total is pending and not taken, not just last beats.
- Zero pairs (self-interaction gives 96'h0) are summed and counted normally.
- fp32 rounding, NaN and Inf behaviour are those of `fp32_add`. Summation order is arrival order.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_ref_id`=0, `out_count`=0, `err_id`=0. State is EMPTY with acc cleared.
- Latency: the last beat accepted in cycle N gives `out_valid`=1 with its total in cycle N+1.
- Sustained rate: one beat per cycle while `out_ready`=1, including back-to-back groups and single-beat groups.
- `out_sum`, `out_ref_id` and `out_count` hold stable while `out_valid && !out_ready`.
- `rst` mid-group discards the partial sum and any pending total. There is no output for the interrupted group.
- `in_valid`=0 in any cycle leaves all state unchanged; gaps inside a group are legal.
- Counter saturation: a group longer than 2^CNT_W-1 beats reports 2^CNT_W-1. The sum is unaffected.

## Test plan
- Group ID 5 with x lanes 1.0 (3F800000), 2.0 (40000000), 0.5 (3F000000, last); y and z = 0. Expect x = 3.5 (40600000), id 5, count 3 one cycle after the last beat.
- Single-beat group: id 9, lanes x/y/z = -1.0 (BF800000) / 1.5 (3FC00000) / 96'h0 lane, last=1. Expect the output equal to the input, count 1, and in_ready never dropping.
- Backpressure:
  - Send a 1.0+1.0 group (id 1), then a 3.0 group (id 2, single beat), with out_ready held 0 for 4 cycles.
  - Expect the first total 2.0 held stable and in_ready=0 while pending.
  - Expect the second total 3.0 (40400000), id 2, after release, with no beat lost.
- ID fault: a beat with id 3 then a last beat with id 4. Expect err_id=1 from the next cycle, a total under id 3 with count 2, and err_id still 1 after later clean groups.
- Reset mid-group: two beats of 1.0 (id 7, not last), rst for 1 cycle, then single beat 2.0 last (id 8). Expect only one output: 2.0, id 8, count 1.
- Saturation with CNT_W=2: a 5-beat group of 1.0. Expect count 3 and sum 5.0 (40A00000).
